// File: rtl/issue_queue.sv
// In-order issue queue: buffers decoded instructions, snoops writeback buses to
// resolve pending operands, and issues the head to ALUs (round-robin), LS or branch.
module issue_queue #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 3,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 4,
    parameter int N_ALU  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_op,
    input  logic [ADDR_W-1:0]           in_pc,
    input  logic [XLEN-1:0]             in_imm,
    input  logic [XLEN-1:0]             in_datax,
    input  logic [XLEN-1:0]             in_datay,
    input  logic [TAG_W-1:0]            in_tagx,
    input  logic [TAG_W-1:0]            in_tagy,
    input  logic [TAG_W-1:0]            in_tagw,
    input  logic [REG_W-1:0]            in_addrw,
    input  logic [N_ALU:0]              wb_en,
    input  logic [(N_ALU+1)*XLEN-1:0]   wb_data,
    input  logic [N_ALU-1:0]            alu_busy,
    input  logic                        ls_busy,
    input  logic                        branch_busy,
    output logic [N_ALU-1:0]            alu_en,
    output logic                        ls_en,
    output logic                        branch_en,
    output logic [3:0]                  iss_op,
    output logic [ADDR_W-1:0]           iss_pc,
    output logic [XLEN-1:0]             iss_imm,
    output logic [XLEN-1:0]             iss_datax,
    output logic [XLEN-1:0]             iss_datay,
    output logic [TAG_W-1:0]            iss_tagx,
    output logic [TAG_W-1:0]            iss_tagy,
    output logic [TAG_W-1:0]            iss_tagw,
    output logic [REG_W-1:0]            iss_addrw,
    output logic                        en_mod,
    output logic [REG_W-1:0]            reg_addr,
    output logic [TAG_W-1:0]            reg_tag,
    output logic                        issued
);

    localparam int NWB   = N_ALU + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (N_ALU > 1) ? $clog2(N_ALU) : 1;

    typedef struct packed {
        logic [7:0]        op;
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   datax;
        logic [XLEN-1:0]   datay;
        logic [TAG_W-1:0]  tagx;
        logic [TAG_W-1:0]  tagy;
        logic [TAG_W-1:0]  tagw;
        logic [REG_W-1:0]  addrw;
    } entry_t;

    // Writeback bus k carries the result for tag k+1; a match captures data and unlocks.
    function automatic entry_t snoop(input entry_t e,
                                     input logic [NWB-1:0] en,
                                     input logic [NWB*XLEN-1:0] data);
        entry_t r;
        r = e;
        for (int k = 0; k < NWB; k++) begin
            if (en[k] && (e.tagx == TAG_W'(k + 1))) begin
                r.datax = data[k*XLEN +: XLEN];
                r.tagx  = '0;
            end
            if (en[k] && (e.tagy == TAG_W'(k + 1))) begin
                r.datay = data[k*XLEN +: XLEN];
                r.tagy  = '0;
            end
            if (en[k] && (e.tagw == TAG_W'(k + 1))) begin
                r.tagw = '0;
            end
        end
        return r;
    endfunction

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RR_W-1:0]    rr_q, rr_d;

    entry_t             head_s, in_s;
    logic               active_s, enq_s;
    logic [3:0]         cls_s;
    logic               found_s;
    int                 idx_s;

    assign in_ready = (count_q < CNT_W'(DEPTH));

    // Head and incoming entries viewed through the same-cycle writeback bypass.
    always_comb begin
        head_s = snoop(ent_q[head_q], wb_en, wb_data);
        in_s   = snoop({in_op, in_pc, in_imm, in_datax, in_datay,
                        in_tagx, in_tagy, in_tagw, in_addrw}, wb_en, wb_data);
    end

    assign cls_s     = head_s.op[7:4];
    assign iss_op    = head_s.op[3:0];
    assign iss_pc    = head_s.pc;
    assign iss_imm   = head_s.imm;
    assign iss_datax = head_s.datax;
    assign iss_datay = head_s.datay;
    assign iss_tagx  = head_s.tagx;
    assign iss_tagy  = head_s.tagy;
    assign iss_tagw  = (cls_s == 4'b0011) ? {TAG_W{1'b0}} : head_s.tagw;
    assign iss_addrw = head_s.addrw;
    assign reg_addr  = head_s.addrw;
    assign active_s  = (count_q != {CNT_W{1'b0}}) && !flush;

    // Class decode and unit grant for the head entry.
    always_comb begin
        alu_en    = '0;
        ls_en     = 1'b0;
        branch_en = 1'b0;
        en_mod    = 1'b0;
        reg_tag   = '0;
        issued    = 1'b0;
        rr_d      = rr_q;
        found_s   = 1'b0;
        idx_s     = 0;
        if (active_s) begin
            case (cls_s)
                4'b0001, 4'b0010, 4'b0101, 4'b1101: begin
                    for (int i = 0; i < N_ALU; i++) begin
                        idx_s = (int'(rr_q) + i) % N_ALU;
                        if (!found_s && !alu_busy[idx_s]) begin
                            found_s       = 1'b1;
                            alu_en[idx_s] = 1'b1;
                            reg_tag       = TAG_W'(idx_s + 1);
                            en_mod        = 1'b1;
                            issued        = 1'b1;
                            rr_d          = RR_W'((idx_s + 1) % N_ALU);
                        end else begin
                            found_s = found_s;
                        end
                    end
                end
                4'b0011, 4'b1001: begin
                    reg_tag = TAG_W'(N_ALU + 1);
                    if (!ls_busy) begin
                        ls_en  = 1'b1;
                        en_mod = 1'b1;
                        issued = 1'b1;
                    end else begin
                        issued = 1'b0;
                    end
                end
                4'b0100: begin
                    if (!branch_busy) begin
                        branch_en = 1'b1;
                        issued    = 1'b1;
                    end else begin
                        issued = 1'b0;
                    end
                end
                default: begin
                    issued = 1'b1;
                end
            endcase
        end else begin
            issued = 1'b0;
        end
    end

    assign enq_s = in_valid && in_ready;

    // Queue next state: snoop every slot, then apply dequeue/enqueue or flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = snoop(ent_q[i], wb_en, wb_data);
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_s) begin
                ent_d[tail_q] = in_s;
                tail_d        = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (issued) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CNT_W'(enq_s) - CNT_W'(issued);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus randomized traffic against a
// queue-based reference model evaluated every cycle.
module tb_issue_queue;

    localparam int XLEN = 32, ADDR_W = 32, TAG_W = 3, REG_W = 5, DEPTH = 4, N_ALU = 2;
    localparam int NWB = N_ALU + 1;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready;
    logic [7:0] in_op;
    logic [ADDR_W-1:0] in_pc;
    logic [XLEN-1:0] in_imm, in_datax, in_datay;
    logic [TAG_W-1:0] in_tagx, in_tagy, in_tagw;
    logic [REG_W-1:0] in_addrw;
    logic [N_ALU:0] wb_en;
    logic [NWB*XLEN-1:0] wb_data;
    logic [N_ALU-1:0] alu_busy;
    logic ls_busy, branch_busy;
    logic [N_ALU-1:0] alu_en;
    logic ls_en, branch_en, en_mod, issued;
    logic [3:0] iss_op;
    logic [ADDR_W-1:0] iss_pc;
    logic [XLEN-1:0] iss_imm, iss_datax, iss_datay;
    logic [TAG_W-1:0] iss_tagx, iss_tagy, iss_tagw, reg_tag;
    logic [REG_W-1:0] iss_addrw, reg_addr;

    always #5 clk = ~clk;

    issue_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .REG_W(REG_W),
                  .DEPTH(DEPTH), .N_ALU(N_ALU)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_datax(in_datax),
        .in_datay(in_datay), .in_tagx(in_tagx), .in_tagy(in_tagy), .in_tagw(in_tagw),
        .in_addrw(in_addrw), .wb_en(wb_en), .wb_data(wb_data), .alu_busy(alu_busy),
        .ls_busy(ls_busy), .branch_busy(branch_busy), .alu_en(alu_en), .ls_en(ls_en),
        .branch_en(branch_en), .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
        .iss_datax(iss_datax), .iss_datay(iss_datay), .iss_tagx(iss_tagx),
        .iss_tagy(iss_tagy), .iss_tagw(iss_tagw), .iss_addrw(iss_addrw),
        .en_mod(en_mod), .reg_addr(reg_addr), .reg_tag(reg_tag), .issued(issued)
    );

    typedef struct {
        logic [7:0] op;
        logic [31:0] pc, imm, dx, dy;
        logic [2:0] tx, ty, tw;
        logic [4:0] aw;
    } ment_t;

    ment_t mq[$];
    ment_t nq[$];
    int rr, nrr;
    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A pending tag t in 1..N_ALU+1 is produced by writeback bus t-1.
    function automatic ment_t resolve(input ment_t e);
        ment_t r = e;
        for (int k = 0; k < NWB; k++) begin
            if (wb_en[k]) begin
                if (e.tx == k + 1) begin r.dx = wb_data[k*XLEN +: XLEN]; r.tx = 0; end
                if (e.ty == k + 1) begin r.dy = wb_data[k*XLEN +: XLEN]; r.ty = 0; end
                if (e.tw == k + 1) r.tw = 0;
            end
        end
        return r;
    endfunction

    task automatic eval_cmp();
        logic [N_ALU-1:0] ealu;
        logic els, ebr, eiss, emod, tagk;
        logic [2:0] etag;
        ment_t h, ni;
        int cls;
        #1;
        ealu = '0; els = 0; ebr = 0; eiss = 0; emod = 0; tagk = 0; etag = 0;
        nrr = rr;
        if (mq.size() > 0 && !flush) begin
            h = resolve(mq[0]);
            cls = int'(h.op[7:4]);
            case (cls)
                1, 2, 5, 13: begin
                    for (int i = 0; i < N_ALU; i++) begin
                        int idx = (rr + i) % N_ALU;
                        if (!alu_busy[idx]) begin
                            ealu[idx] = 1; etag = 3'(idx + 1); emod = 1; eiss = 1; tagk = 1;
                            nrr = (idx + 1) % N_ALU;
                            break;
                        end
                    end
                end
                3, 9: begin
                    etag = 3'(N_ALU + 1); tagk = 1;
                    if (!ls_busy) begin els = 1; emod = 1; eiss = 1; end
                end
                4: begin
                    tagk = 1; etag = 0;
                    if (!branch_busy) begin ebr = 1; eiss = 1; end
                end
                default: eiss = 1;
            endcase
        end
        check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        if (!rst) begin
            check("alu_en", 64'(alu_en), 64'(ealu));
            check("ls_en", 64'(ls_en), 64'(els));
            check("branch_en", 64'(branch_en), 64'(ebr));
            check("issued", 64'(issued), 64'(eiss));
            check("en_mod", 64'(en_mod), 64'(emod));
            if (tagk) check("reg_tag", 64'(reg_tag), 64'(etag));
            if (mq.size() > 0 && !flush) begin
                check("iss_op", 64'(iss_op), 64'(h.op[3:0]));
                check("iss_pc", 64'(iss_pc), 64'(h.pc));
                check("iss_imm", 64'(iss_imm), 64'(h.imm));
                check("iss_datax", 64'(iss_datax), 64'(h.dx));
                check("iss_datay", 64'(iss_datay), 64'(h.dy));
                check("iss_tagx", 64'(iss_tagx), 64'(h.tx));
                check("iss_tagy", 64'(iss_tagy), 64'(h.ty));
                check("iss_tagw", 64'(iss_tagw), 64'((h.op[7:4] == 4'h3) ? 3'd0 : h.tw));
                check("iss_addrw", 64'(iss_addrw), 64'(h.aw));
                check("reg_addr", 64'(reg_addr), 64'(h.aw));
            end
        end
        nq.delete();
        if (rst) begin
            nrr = 0;
        end else if (!flush) begin
            foreach (mq[i]) nq.push_back(resolve(mq[i]));
            if (eiss) void'(nq.pop_front());
            if (in_valid && mq.size() < DEPTH) begin
                ni.op = in_op; ni.pc = in_pc; ni.imm = in_imm; ni.dx = in_datax;
                ni.dy = in_datay; ni.tx = in_tagx; ni.ty = in_tagy; ni.tw = in_tagw;
                ni.aw = in_addrw;
                nq.push_back(resolve(ni));
            end
        end
    endtask

    task automatic commit();
        @(posedge clk);
        mq = nq;
        rr = nrr;
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; in_op = 0; in_pc = 0; in_imm = 0;
        in_datax = 0; in_datay = 0; in_tagx = 0; in_tagy = 0; in_tagw = 0; in_addrw = 0;
        wb_en = 0; wb_data = 0; alu_busy = 0; ls_busy = 0; branch_busy = 0;
    endtask

    task automatic offer(input logic [7:0] op);
        in_valid = 1; in_op = op; in_pc = $urandom; in_imm = $urandom;
        in_datax = $urandom; in_datay = $urandom; in_addrw = 5'($urandom);
        in_tagx = 0; in_tagy = 0; in_tagw = 0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); idle(); eval_cmp(); commit();
        end
    endtask

    logic [7:0] classes [10];

    initial begin
        classes = '{8'h10, 8'h20, 8'h50, 8'hD0, 8'h30, 8'h90, 8'h40, 8'h00, 8'h70, 8'hF0};
        idle();
        rst = 1; rr = 0; nrr = 0;
        @(posedge clk); @(posedge clk);

        // ALU round-robin
        @(negedge clk); idle(); offer(8'h10); eval_cmp();
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_issued", 64'(issued), 64'd0);
        commit();
        @(negedge clk); idle(); offer(8'h11); eval_cmp();
        check("rr_alu0", 64'(alu_en), 64'h1); check("rr_tag1", 64'(reg_tag), 64'd1); commit();
        @(negedge clk); idle(); offer(8'h12); eval_cmp();
        check("rr_alu1", 64'(alu_en), 64'h2); check("rr_tag2", 64'(reg_tag), 64'd2); commit();
        @(negedge clk); idle(); eval_cmp();
        check("rr_alu0b", 64'(alu_en), 64'h1); check("rr_tag1b", 64'(reg_tag), 64'd1); commit();

        // Full queue behind busy LS
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); ls_busy = 1; offer(8'h91); eval_cmp(); commit();
        end
        @(negedge clk); idle(); ls_busy = 1; offer(8'h91); eval_cmp();
        check("full_ready", 64'(in_ready), 64'd0); commit();
        @(negedge clk); idle(); eval_cmp();
        check("ls_en", 64'(ls_en), 64'd1); check("ls_tag", 64'(reg_tag), 64'd3);
        check("full_ready_still", 64'(in_ready), 64'd0); commit();
        @(negedge clk); idle(); ls_busy = 1; eval_cmp();
        check("ready_back", 64'(in_ready), 64'd1); commit();
        run_idle(4);

        // Snoop while waiting behind a stalled head
        @(negedge clk); idle(); ls_busy = 1; offer(8'h91); eval_cmp(); commit();
        @(negedge clk); idle(); ls_busy = 1; offer(8'h10); in_tagx = 2; in_datax = 0;
        eval_cmp(); commit();
        @(negedge clk); idle(); ls_busy = 1; wb_en = 3'b010; wb_data[XLEN +: XLEN] = 32'hDEADBEEF;
        eval_cmp(); commit();
        @(negedge clk); idle(); eval_cmp(); commit();
        @(negedge clk); idle(); eval_cmp();
        check("snoop_datax", 64'(iss_datax), 64'hDEADBEEF);
        check("snoop_tagx", 64'(iss_tagx), 64'd0); commit();

        // Same-cycle bypass on the head
        @(negedge clk); idle(); offer(8'h10); in_tagy = 3; in_datay = 0; eval_cmp(); commit();
        @(negedge clk); idle(); wb_en = 3'b100; wb_data[2*XLEN +: XLEN] = 32'h55; eval_cmp();
        check("bypass_datay", 64'(iss_datay), 64'h55);
        check("bypass_tagy", 64'(iss_tagy), 64'd0);
        check("bypass_issued", 64'(issued), 64'd1); commit();

        // Flush discards queue and concurrent enqueue
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); ls_busy = 1; offer(8'h91); eval_cmp(); commit();
        end
        @(negedge clk); idle(); flush = 1; offer(8'h10); eval_cmp();
        check("flush_issued", 64'(issued), 64'd0); check("flush_alu", 64'(alu_en), 64'd0);
        check("flush_ls", 64'(ls_en), 64'd0); commit();
        @(negedge clk); idle(); eval_cmp();
        check("post_flush_issued", 64'(issued), 64'd0);
        check("post_flush_ready", 64'(in_ready), 64'd1); commit();

        // Branch stall, then dropped class
        @(negedge clk); idle(); branch_busy = 1; offer(8'h40); eval_cmp(); commit();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); idle(); branch_busy = 1; eval_cmp();
            check("br_stall_en", 64'(branch_en), 64'd0); check("br_stall_mod", 64'(en_mod), 64'd0);
            commit();
        end
        @(negedge clk); idle(); offer(8'h00); eval_cmp();
        check("br_en", 64'(branch_en), 64'd1); check("br_mod", 64'(en_mod), 64'd0); commit();
        @(negedge clk); idle(); eval_cmp();
        check("drop_issued", 64'(issued), 64'd1); check("drop_alu", 64'(alu_en), 64'd0);
        check("drop_ls", 64'(ls_en), 64'd0); check("drop_br", 64'(branch_en), 64'd0);
        check("drop_mod", 64'(en_mod), 64'd0); commit();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle();
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) != 0) begin
                offer(classes[$urandom_range(0, 9)] | 8'($urandom_range(0, 15)));
                in_tagx = 3'($urandom_range(0, 4));
                in_tagy = 3'($urandom_range(0, 4));
                in_tagw = 3'($urandom_range(0, 4));
            end
            wb_en = 3'($urandom);
            wb_data = {$urandom, $urandom, $urandom};
            alu_busy = 2'($urandom);
            ls_busy = ($urandom_range(0, 2) == 0);
            branch_busy = ($urandom_range(0, 2) == 0);
            eval_cmp();
            commit();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
